// File: rtl/channel_pkg.sv
// Shared encodings for the parallel-channel engine: FSM states, result codes and
// status-byte bit positions.
package channel_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEL_ADDR,
        ST_SEL_SELECT,
        ST_SEL_ADDR_IN,
        ST_SEL_CMD,
        ST_SEL_STATUS,
        ST_SEL_SVC,
        ST_SELECTED,
        ST_SEND,
        ST_SEND_ACK,
        ST_RECV,
        ST_RECV_ACK,
        ST_STOP,
        ST_ENDING
    } state_t;

    typedef enum logic [2:0] {
        RES_OK         = 3'd0,
        RES_SHORT_BUSY = 3'd1,
        RES_NO_DEVICE  = 3'd2,
        RES_UNIT_CHECK = 3'd3,
        RES_TIMEOUT    = 3'd4,
        RES_PARITY     = 3'd5
    } result_t;

    localparam int STAT_DE   = 2;
    localparam int STAT_UC   = 1;
    localparam int STAT_BUSY = 4;
    localparam logic [7:0] STATUS_SHORT_BUSY = 8'h10;

    // States where the engine is waiting on the device and the interface timer runs.
    function automatic logic is_wait_state(input state_t s);
        return !(s inside {ST_IDLE, ST_SEL_ADDR, ST_SEND, ST_RECV});
    endfunction

endpackage

// File: rtl/channel_timeout.sv
// Per-state interface timer: reloads on clear or when idle, counts down while
// enabled, and flags expiry once TIMEOUT_CYCLES have elapsed in one state.
module channel_timeout
    import channel_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES);

    logic [W-1:0] remaining;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= LOAD;
        end else if (clear || !enable) begin
            remaining <= LOAD;
        end else if (remaining != '0) begin
            remaining <= remaining - W'(1);
        end
    end

    // Masked by clear so a count left over from the previous state never fires.
    assign expired = enable && !clear && (remaining == '0);

endmodule

// File: rtl/channel_engine.sv
// Bus-and-tag channel engine: selection, counted byte transfer, stop and ending status.
// Optional inbound/outbound bus parity is enabled by defining CHANNEL_PARITY_EN.
module channel_engine
    import channel_pkg::*;
#(
    parameter int ADDR_SETUP_CYCLES = 4,
    parameter int TIMEOUT_CYCLES    = 4096,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             a_bus_in,
    output logic [7:0]             a_bus_out,
    output logic                   a_operational_out,
    output logic                   a_hold_out,
    output logic                   a_select_out,
    output logic                   a_address_out,
    output logic                   a_command_out,
    output logic                   a_service_out,
    output logic                   a_suppress_out,
    input  logic                   a_operational_in,
    input  logic                   a_select_in,
    input  logic                   a_address_in,
    input  logic                   a_status_in,
    input  logic                   a_service_in,
    input  logic                   a_request_in,
    input  logic [7:0]             addr,
    input  logic [7:0]             command,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic                   start,
    input  logic                   stop,
    output logic                   active,
    output logic [COUNT_WIDTH-1:0] residual,
    output logic                   done,
    output logic [2:0]             result,
    output logic [7:0]             status_tdata,
    output logic                   status_tvalid,
    input  logic [7:0]             data_send_tdata,
    input  logic                   data_send_tvalid,
    output logic                   data_send_tready,
`ifdef CHANNEL_PARITY_EN
    input  logic                   a_bus_in_p,
    output logic                   a_bus_out_p,
`endif
    output logic [7:0]             data_recv_tdata,
    output logic                   data_recv_tvalid,
    input  logic                   data_recv_tready
);
    // States: IDLE wait start | SEL_* selection and initial status | SELECTED wait
    // service/status | SEND(_ACK)/RECV(_ACK) one byte | STOP command-out stop | ENDING status.
    localparam int SETUP_W = (ADDR_SETUP_CYCLES > 1) ? $clog2(ADDR_SETUP_CYCLES) : 1;
    localparam logic [SETUP_W-1:0] SETUP_LOAD = SETUP_W'(ADDR_SETUP_CYCLES - 1);

    state_t               state, prev_state;
    logic [7:0]           addr_q, cmd_q, stat_q;
    logic [SETUP_W-1:0]   setup_cnt;
    logic                 short_busy, par_err, bad_par;
    logic                 tmo_clear, tmo_enable, tmo_expired;
    logic                 unused_request;

    assign unused_request = a_request_in;
    assign active         = (state != ST_IDLE);
    assign tmo_clear      = (state != prev_state);
    assign tmo_enable     = is_wait_state(state);

`ifdef CHANNEL_PARITY_EN
    assign bad_par     = ~(^{a_bus_in, a_bus_in_p});
    assign a_bus_out_p = ~(^a_bus_out);
`else
    assign bad_par = 1'b0;
`endif

    channel_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    task automatic end_op(input result_t code);
        state            <= ST_IDLE;
        done             <= 1'b1;
        result           <= code;
        a_hold_out       <= 1'b0;
        a_select_out     <= 1'b0;
        a_address_out    <= 1'b0;
        a_command_out    <= 1'b0;
        a_service_out    <= 1'b0;
        a_bus_out        <= '0;
        data_send_tready <= 1'b0;
        data_recv_tvalid <= 1'b0;
    endtask

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            prev_state        <= ST_IDLE;
            addr_q            <= '0;
            cmd_q             <= '0;
            stat_q            <= '0;
            setup_cnt         <= '0;
            short_busy        <= 1'b0;
            par_err           <= 1'b0;
            a_bus_out         <= '0;
            a_operational_out <= 1'b0;
            a_hold_out        <= 1'b0;
            a_select_out      <= 1'b0;
            a_address_out     <= 1'b0;
            a_command_out     <= 1'b0;
            a_service_out     <= 1'b0;
            a_suppress_out    <= 1'b0;
            residual          <= '0;
            done              <= 1'b0;
            result            <= '0;
            status_tdata      <= '0;
            status_tvalid     <= 1'b0;
            data_send_tready  <= 1'b0;
            data_recv_tdata   <= '0;
            data_recv_tvalid  <= 1'b0;
        end else begin
            done              <= 1'b0;
            status_tvalid     <= 1'b0;
            a_operational_out <= 1'b1;
            prev_state        <= state;
            if (tmo_expired) begin
                end_op(RES_TIMEOUT);
            end else begin
                case (state)
                    ST_IDLE: if (start && !a_select_in && !a_status_in && !a_operational_in) begin
                        addr_q        <= addr;
                        cmd_q         <= command;
                        residual      <= count;
                        short_busy    <= 1'b0;
                        par_err       <= 1'b0;
                        a_bus_out     <= addr;
                        a_address_out <= 1'b1;
                        setup_cnt     <= SETUP_LOAD;
                        state         <= ST_SEL_ADDR;
                    end
                    ST_SEL_ADDR: if (setup_cnt == '0) begin
                        a_hold_out   <= 1'b1;
                        a_select_out <= 1'b1;
                        state        <= ST_SEL_SELECT;
                    end else begin
                        setup_cnt <= setup_cnt - SETUP_W'(1);
                    end
                    ST_SEL_SELECT: if (a_operational_in) begin
                        a_address_out <= 1'b0;
                        a_bus_out     <= '0;
                        state         <= ST_SEL_ADDR_IN;
                    end else if (a_status_in) begin
                        if (bad_par) end_op(RES_PARITY);
                        else if (a_bus_in == STATUS_SHORT_BUSY) begin
                            stat_q        <= a_bus_in;
                            short_busy    <= 1'b1;
                            a_service_out <= 1'b1;
                            state         <= ST_SEL_SVC;
                        end
                    end else if (a_select_in) begin
                        end_op(RES_NO_DEVICE);
                    end
                    ST_SEL_ADDR_IN: if (a_address_in) begin
                        if (bad_par) end_op(RES_PARITY);
                        else if (a_bus_in != addr_q) end_op(RES_TIMEOUT);
                        else begin
                            a_bus_out     <= cmd_q;
                            a_command_out <= 1'b1;
                            state         <= ST_SEL_CMD;
                        end
                    end
                    ST_SEL_CMD: if (!a_address_in) begin
                        a_command_out <= 1'b0;
                        a_bus_out     <= '0;
                        state         <= ST_SEL_STATUS;
                    end
                    ST_SEL_STATUS: if (a_status_in) begin
                        if (bad_par) end_op(RES_PARITY);
                        else begin
                            stat_q        <= a_bus_in;
                            status_tdata  <= a_bus_in;
                            status_tvalid <= 1'b1;
                            a_service_out <= 1'b1;
                            state         <= ST_SEL_SVC;
                        end
                    end
                    ST_SEL_SVC: if (!a_status_in) begin
                        a_service_out <= 1'b0;
                        if (short_busy) end_op(RES_SHORT_BUSY);
                        else if (stat_q == 8'h00 && cmd_q != 8'h00) state <= ST_SELECTED;
                        else end_op(stat_q[STAT_UC] ? RES_UNIT_CHECK : RES_OK);
                    end
                    ST_SELECTED: if (a_service_in) begin
                        if (stop || residual == '0) begin
                            a_command_out <= 1'b1;
                            state         <= ST_STOP;
                        end else if (cmd_q[0]) begin
                            data_send_tready <= 1'b1;
                            state            <= ST_SEND;
                        end else if (bad_par) begin
                            par_err       <= 1'b1;
                            a_command_out <= 1'b1;
                            state         <= ST_STOP;
                        end else begin
                            data_recv_tdata  <= a_bus_in;
                            data_recv_tvalid <= 1'b1;
                            state            <= ST_RECV;
                        end
                    end else if (a_status_in) begin
                        if (bad_par) end_op(RES_PARITY);
                        else begin
                            stat_q        <= a_bus_in;
                            status_tdata  <= a_bus_in;
                            status_tvalid <= 1'b1;
                            a_service_out <= 1'b1;
                            state         <= ST_ENDING;
                        end
                    end
                    ST_SEND: if (stop) begin
                        data_send_tready <= 1'b0;
                        a_command_out    <= 1'b1;
                        state            <= ST_STOP;
                    end else if (data_send_tvalid && data_send_tready) begin
                        a_bus_out        <= data_send_tdata;
                        a_service_out    <= 1'b1;
                        data_send_tready <= 1'b0;
                        residual         <= (residual == '0) ? '0 : residual - COUNT_WIDTH'(1);
                        state            <= ST_SEND_ACK;
                    end
                    ST_SEND_ACK: if (!a_service_in) begin
                        a_service_out <= 1'b0;
                        a_bus_out     <= '0;
                        state         <= ST_SELECTED;
                    end
                    ST_RECV: if (stop) begin
                        data_recv_tvalid <= 1'b0;
                        a_command_out    <= 1'b1;
                        state            <= ST_STOP;
                    end else if (data_recv_tready) begin
                        data_recv_tvalid <= 1'b0;
                        a_service_out    <= 1'b1;
                        residual         <= (residual == '0) ? '0 : residual - COUNT_WIDTH'(1);
                        state            <= ST_RECV_ACK;
                    end
                    ST_RECV_ACK: if (!a_service_in) begin
                        a_service_out <= 1'b0;
                        state         <= ST_SELECTED;
                    end
                    ST_STOP: if (!a_service_in) begin
                        a_command_out <= 1'b0;
                        if (par_err) end_op(RES_PARITY);
                        else state <= ST_SELECTED;
                    end
                    ST_ENDING: if (!a_status_in) begin
                        a_service_out <= 1'b0;
                        if (stat_q[STAT_DE]) end_op(stat_q[STAT_UC] ? RES_UNIT_CHECK : RES_OK);
                        else state <= ST_SELECTED;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_channel_engine.sv
// Directed bench for channel_engine: plays the device side of the bus-and-tag
// interface and the host streams, checking each step against hand-derived values.
module tb_channel_engine;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  a_bus_in, a_bus_out;
    logic        a_operational_out, a_hold_out, a_select_out, a_address_out;
    logic        a_command_out, a_service_out, a_suppress_out;
    logic        a_operational_in, a_select_in, a_address_in, a_status_in, a_service_in, a_request_in;
    logic [7:0]  addr, command;
    logic [15:0] count, residual;
    logic        start, stop, active, done;
    logic [2:0]  result;
    logic [7:0]  status_tdata, data_send_tdata, data_recv_tdata;
    logic        status_tvalid, data_send_tvalid, data_send_tready;
    logic        data_recv_tvalid, data_recv_tready;
`ifdef CHANNEL_PARITY_EN
    logic        a_bus_in_p, a_bus_out_p, par_flip;
    assign a_bus_in_p = (~(^a_bus_in)) ^ par_flip;
`endif

    int n_cmp = 0;
    int n_err = 0;

    localparam int W_SVC = 0, W_CMD = 1, W_SEL = 2, W_ADR = 3, W_DONE = 4, W_RVALID = 5;

    always #5 clk = ~clk;

    channel_engine dut (
        .clk(clk), .reset_n(reset_n),
        .a_bus_in(a_bus_in), .a_bus_out(a_bus_out),
        .a_operational_out(a_operational_out), .a_hold_out(a_hold_out),
        .a_select_out(a_select_out), .a_address_out(a_address_out),
        .a_command_out(a_command_out), .a_service_out(a_service_out),
        .a_suppress_out(a_suppress_out),
        .a_operational_in(a_operational_in), .a_select_in(a_select_in),
        .a_address_in(a_address_in), .a_status_in(a_status_in),
        .a_service_in(a_service_in), .a_request_in(a_request_in),
        .addr(addr), .command(command), .count(count),
        .start(start), .stop(stop), .active(active), .residual(residual),
        .done(done), .result(result),
        .status_tdata(status_tdata), .status_tvalid(status_tvalid),
        .data_send_tdata(data_send_tdata), .data_send_tvalid(data_send_tvalid),
        .data_send_tready(data_send_tready),
`ifdef CHANNEL_PARITY_EN
        .a_bus_in_p(a_bus_in_p), .a_bus_out_p(a_bus_out_p),
`endif
        .data_recv_tdata(data_recv_tdata), .data_recv_tvalid(data_recv_tvalid),
        .data_recv_tready(data_recv_tready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic wait_out(input int sel, input logic lvl, input string tag);
        logic seen;
        logic cur;
        seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            case (sel)
                W_SVC:    cur = a_service_out;
                W_CMD:    cur = a_command_out;
                W_SEL:    cur = a_select_out;
                W_ADR:    cur = a_address_out;
                W_DONE:   cur = done;
                W_RVALID: cur = data_recv_tvalid;
                default:  cur = 1'bx;
            endcase
            seen = (cur === lvl);
        end
        n_cmp++;
        assert (seen) else begin
            n_err++;
            $error("FAIL %s: wait expired, observed %0b expected %0b", tag, !lvl, lvl);
        end
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] c, input logic [15:0] n);
        int setup;
        int guard;
        @(negedge clk);
        addr = a; command = c; count = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("addr_bus", a_bus_out, a);
        setup = 0;
        guard = 0;
        while (a_select_out !== 1'b1 && guard < 50) begin
            if (a_address_out === 1'b1 && a_select_out === 1'b0) setup++;
            @(negedge clk);
            guard++;
        end
        chk("addr_setup", setup, 4);
        chk("hold_with_select", a_hold_out, 1);
    endtask

    task automatic select_ok(input logic [7:0] a, input logic [7:0] c, input logic [15:0] n);
        start_op(a, c, n);
        a_operational_in = 1'b1;
        wait_out(W_ADR, 1'b0, "addr_drop");
        a_address_in = 1'b1; a_bus_in = a;
        wait_out(W_CMD, 1'b1, "cmd_rise");
        chk("cmd_byte", a_bus_out, c);
        a_address_in = 1'b0; a_status_in = 1'b1; a_bus_in = 8'h00;
        wait_out(W_SVC, 1'b1, "init_svc");
        chk("init_stat_valid", status_tvalid, 1);
        chk("init_stat_data", status_tdata, 8'h00);
        a_status_in = 1'b0;
        wait_out(W_SVC, 1'b0, "init_svc_drop");
    endtask

    task automatic ending(input logic [7:0] st, input logic [2:0] res, input logic [15:0] resid);
        a_status_in = 1'b1; a_bus_in = st;
        wait_out(W_SVC, 1'b1, "end_svc");
        chk("end_stat_data", status_tdata, st);
        a_status_in = 1'b0; a_bus_in = 8'h00;
        wait_out(W_DONE, 1'b1, "end_done");
        chk("end_result", result, res);
        chk("end_residual", residual, resid);
        chk("end_active", active, 0);
        chk("end_select", a_select_out, 0);
        a_operational_in = 1'b0;
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        a_bus_in = '0; a_operational_in = 0; a_select_in = 0; a_address_in = 0;
        a_status_in = 0; a_service_in = 0; a_request_in = 0;
        addr = '0; command = '0; count = '0; start = 0; stop = 0;
        data_send_tdata = '0; data_send_tvalid = 0; data_recv_tready = 0;
`ifdef CHANNEL_PARITY_EN
        par_flip = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_tags", {a_operational_out, a_hold_out, a_select_out, a_address_out,
                         a_command_out, a_service_out, a_suppress_out}, 0);
        chk("rst_bus", a_bus_out, 0);
        chk("rst_misc", {done, result, status_tvalid, data_send_tready, data_recv_tvalid, active}, 0);
        chk("rst_residual", residual, 0);
        reset_n = 1'b1;
        #1 chk("op_before_clk", a_operational_out, 0);
        @(negedge clk);
        chk("op_after_clk", a_operational_out, 1);

        // start is refused while the device still has operational_in up
        a_operational_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("start_blocked", active, 0);
        a_operational_in = 1'b0;

        // write of three bytes
        select_ok(8'h0E, 8'h01, 16'd3);
        for (int i = 0; i < 3; i++) begin
            data_send_tdata = 8'hA0 + 8'(i); data_send_tvalid = 1'b1; a_service_in = 1'b1;
            wait_out(W_SVC, 1'b1, "wr_svc");
            chk("wr_byte", a_bus_out, 8'hA0 + 8'(i));
            data_send_tvalid = 1'b0; a_service_in = 1'b0;
            wait_out(W_SVC, 1'b0, "wr_svc_drop");
        end
        ending(8'h0C, 3'd0, 16'd0);

        // read of two bytes with the third service_in answered by command_out
        data_recv_tready = 1'b1;
        select_ok(8'h21, 8'h02, 16'd2);
        for (int i = 0; i < 2; i++) begin
            a_bus_in = 8'h50 + 8'(i); a_service_in = 1'b1;
            wait_out(W_SVC, 1'b1, "rd_svc");
            chk("rd_byte", data_recv_tdata, 8'h50 + 8'(i));
            a_service_in = 1'b0;
            wait_out(W_SVC, 1'b0, "rd_svc_drop");
        end
        a_bus_in = 8'h52; a_service_in = 1'b1;
        wait_out(W_CMD, 1'b1, "auto_stop");
        chk("auto_stop_no_svc", a_service_out, 0);
        chk("auto_stop_no_valid", data_recv_tvalid, 0);
        a_service_in = 1'b0;
        wait_out(W_CMD, 1'b0, "auto_stop_drop");
        ending(8'h0C, 3'd0, 16'd0);

        // count 0: first service answered by command_out; DE+UC ending gives unit check
        select_ok(8'h05, 8'h01, 16'd0);
        a_service_in = 1'b1;
        wait_out(W_CMD, 1'b1, "zero_cnt_stop");
        chk("zero_cnt_no_svc", a_service_out, 0);
        a_service_in = 1'b0;
        wait_out(W_CMD, 1'b0, "zero_cnt_drop");
        ending(8'h06, 3'd3, 16'd0);

        // host stop during RECV leaves the count untouched
        data_recv_tready = 1'b0;
        select_ok(8'h22, 8'h02, 16'd5);
        a_bus_in = 8'h77; a_service_in = 1'b1;
        wait_out(W_RVALID, 1'b1, "recv_valid");
        stop = 1'b1;
        wait_out(W_CMD, 1'b1, "host_stop");
        chk("host_stop_valid", data_recv_tvalid, 0);
        chk("host_stop_no_svc", a_service_out, 0);
        stop = 1'b0; a_service_in = 1'b0;
        wait_out(W_CMD, 1'b0, "host_stop_drop");
        ending(8'h0C, 3'd0, 16'd5);

        // short busy on selection
        start_op(8'h33, 8'h01, 16'd1);
        a_status_in = 1'b1; a_bus_in = 8'h10;
        wait_out(W_SVC, 1'b1, "busy_svc");
        chk("busy_no_cmd", a_command_out, 0);
        a_status_in = 1'b0; a_bus_in = 8'h00;
        wait_out(W_DONE, 1'b1, "busy_done");
        chk("busy_result", result, 3'd1);
        chk("busy_residual", residual, 16'd1);

        // select propagates back: no device
        start_op(8'h34, 8'h01, 16'd1);
        a_select_in = 1'b1;
        wait_out(W_DONE, 1'b1, "nodev_done");
        chk("nodev_result", result, 3'd2);
        a_select_in = 1'b0;

        // no operational_in after select_out: timeout after 4096 cycles
        start_op(8'h44, 8'h01, 16'd1);
        repeat (4000) @(negedge clk);
        chk("tmo_still_active", {active, a_select_out}, 2'b11);
        wait_out(W_DONE, 1'b1, "tmo_done");
        chk("tmo_result", result, 3'd4);
        chk("tmo_tags", {a_hold_out, a_select_out, a_address_out, a_command_out, a_service_out}, 0);
        chk("tmo_active", active, 0);

        // reset asserted while in RECV_ACK
        data_recv_tready = 1'b1;
        select_ok(8'h21, 8'h02, 16'd2);
        a_bus_in = 8'h60; a_service_in = 1'b1;
        wait_out(W_SVC, 1'b1, "rst_recv_ack");
        reset_n = 1'b0;
        #1;
        chk("midrst_tags", {a_operational_out, a_hold_out, a_select_out, a_address_out,
                            a_command_out, a_service_out}, 0);
        chk("midrst_active", active, 0);
        a_service_in = 1'b0; a_operational_in = 1'b0; a_bus_in = 8'h00; data_recv_tready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("midrst_op_low", a_operational_out, 0);
        @(negedge clk);
        chk("midrst_op_high", a_operational_out, 1);
        begin
            int dn;
            dn = 0;
            repeat (5) begin
                if (done === 1'b1) dn++;
                @(negedge clk);
            end
            chk("midrst_no_done", dn, 0);
        end

`ifdef CHANNEL_PARITY_EN
        // initial status byte with even parity
        start_op(8'h0E, 8'h01, 16'd1);
        a_operational_in = 1'b1;
        wait_out(W_ADR, 1'b0, "par_addr_drop");
        a_address_in = 1'b1; a_bus_in = 8'h0E;
        wait_out(W_CMD, 1'b1, "par_cmd");
        a_address_in = 1'b0; a_status_in = 1'b1; a_bus_in = 8'h00; par_flip = 1'b1;
        wait_out(W_DONE, 1'b1, "par_done");
        chk("par_result", result, 3'd5);
        a_status_in = 1'b0; par_flip = 1'b0; a_operational_in = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
